alu_cmd_issue: RTL and testbench

Command-issue stage that sits directly upstream of the enum-driven combinational ALU. It accepts (a, b, op) commands over a valid/ready handshake and buffers them in a small FIFO. It drives the FIFO head onto the ALU operand/op inputs, captures the ALU result into an output register, and presents it downstream over a second valid/ready handshake. It is the sequencing and backpressure boundary around the purely combinational ALU.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_cmd_issue_if.sv | 40 ++++
 rtl/alu_cmd_fifo.sv | 66 ++++++
 rtl/alu_cmd_issue.sv | 117 +++++++++++
 tb/tb_alu_cmd_issue.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: the operation encoding, the command record and
// the legal-op test used by the issue stage and by the ALU itself.
package alu_pkg;

    localparam int ALU_W = 8;

    // One-hot-ish encodings inherited from the ALU; 000, 101 and 111 are unused.
    typedef enum bit [2:0] {
        ADD = 3'b100,
        SUB = 3'b010,
        AND = 3'b001,
        OR  = 3'b110,
        XOR = 3'b011
    } aluFun_t;

    typedef struct packed {
        logic [ALU_W-1:0] a;
        logic [ALU_W-1:0] b;
        aluFun_t          op;
    } alu_cmd_t;

    // True only for the five encodings the ALU implements.
    function automatic logic is_legal_op(input aluFun_t op);
        logic legal_v;
        case (op)
            ADD, SUB, AND, OR, XOR: legal_v = 1'b1;
            default:                legal_v = 1'b0;
        endcase
        return legal_v;
    endfunction

endpackage

// File: rtl/alu_cmd_issue_if.sv
// Bundle of the command, ALU-drive and response signals around the issue stage.
// master = environment side (upstream source, ALU, downstream sink),
// slave  = the issue stage itself.
interface alu_cmd_issue_if
    import alu_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          cmd_valid;
    logic          cmd_ready;
    logic [W-1:0]  cmd_a;
    logic [W-1:0]  cmd_b;
    logic [2:0]    cmd_op;      // raw bits: illegal encodings may arrive here
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    aluFun_t       alu_op;
    logic [W-1:0]  alu_result;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_result;
    aluFun_t       rsp_op;
    logic          err_illegal;
    logic [CW-1:0] count;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, alu_result, rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_result,
               rsp_op, err_illegal, count
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_result, rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_result,
               rsp_op, err_illegal, count
    );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO of ALU commands. Pointers wrap naturally at DEPTH (a power
// of two); the separate occupancy counter tells full from empty. A push while
// full or a pop while empty is ignored, so the caller's gating is not trusted.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = alu_cmd_t
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  entry_t                     push_data,
    input  logic                       pop,
    output entry_t                     head,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    entry_t          mem_r [DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic            push_ok_s;
    logic            pop_ok_s;

    // Qualify the requests against the current occupancy.
    always_comb begin
        push_ok_s = push && (count_r < DEPTH_C);
        pop_ok_s  = pop && (count_r != {CW{1'b0}});
    end

    // Storage, pointers and occupancy; push and pop in one cycle leave count unchanged.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Present the oldest entry and the occupancy.
    always_comb begin
        head  = mem_r[rd_ptr_r];
        count = count_r;
    end

endmodule

// File: rtl/alu_cmd_issue.sv
// Command-issue stage in front of the combinational ALU: buffers accepted
// commands, drives the oldest one onto the ALU, captures the result into an
// output register and hands it downstream under valid/ready backpressure.
module alu_cmd_issue
    import alu_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic            clock,
    input  logic            reset,
    alu_cmd_issue_if.slave  bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        aluFun_t      op;
    } entry_t;

    entry_t         push_data_s;
    entry_t         head_s;
    logic [CW-1:0]  count_s;
    logic           cmd_ready_s;
    logic           op_legal_s;
    logic           cmd_fire_s;
    logic           push_s;
    logic           pop_s;
    logic           rsp_valid_r;
    logic [W-1:0]   rsp_result_r;
    aluFun_t        rsp_op_r;
    logic           err_illegal_r;

    // Handshake decode; readiness depends only on occupancy so a full FIFO
    // refuses even when the head is leaving in the same cycle.
    always_comb begin
        cmd_ready_s       = (count_s < DEPTH_C);
        op_legal_s        = is_legal_op(aluFun_t'(bus.cmd_op));
        cmd_fire_s        = bus.cmd_valid && cmd_ready_s;
        push_s            = cmd_fire_s && op_legal_s;
        pop_s             = (count_s != {CW{1'b0}}) && (!rsp_valid_r || bus.rsp_ready);
        push_data_s.a     = bus.cmd_a;
        push_data_s.b     = bus.cmd_b;
        push_data_s.op    = aluFun_t'(bus.cmd_op);
    end

    alu_cmd_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .head      (head_s),
        .count     (count_s)
    );

    // Feed the ALU from the FIFO head, or a harmless 0 + 0 when idle.
    always_comb begin
        if (count_s != {CW{1'b0}}) begin
            bus.alu_a  = head_s.a;
            bus.alu_b  = head_s.b;
            bus.alu_op = head_s.op;
        end else begin
            bus.alu_a  = {W{1'b0}};
            bus.alu_b  = {W{1'b0}};
            bus.alu_op = ADD;
        end
    end

    // Output register: capture on issue, drop valid once taken, hold while stalled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rsp_valid_r  <= 1'b0;
            rsp_result_r <= {W{1'b0}};
            rsp_op_r     <= ADD;
        end else if (pop_s) begin
            rsp_valid_r  <= 1'b1;
            rsp_result_r <= bus.alu_result;
            rsp_op_r     <= head_s.op;
        end else if (bus.rsp_ready) begin
            rsp_valid_r  <= 1'b0;
            rsp_result_r <= rsp_result_r;
            rsp_op_r     <= rsp_op_r;
        end else begin
            rsp_valid_r  <= rsp_valid_r;
            rsp_result_r <= rsp_result_r;
            rsp_op_r     <= rsp_op_r;
        end
    end

    // Sticky flag for an accepted command carrying an unimplemented encoding.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_illegal_r <= 1'b0;
        end else if (cmd_fire_s && !op_legal_s) begin
            err_illegal_r <= 1'b1;
        end else begin
            err_illegal_r <= err_illegal_r;
        end
    end

    // Drive the bus outputs.
    always_comb begin
        bus.cmd_ready   = cmd_ready_s;
        bus.rsp_valid   = rsp_valid_r;
        bus.rsp_result  = rsp_result_r;
        bus.rsp_op      = rsp_op_r;
        bus.err_illegal = err_illegal_r;
        bus.count       = count_s;
    end

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Self-checking bench for alu_cmd_issue: a table of streamed vectors with a
// result scoreboard, plus hand-written backpressure, illegal-op, full-FIFO
// and mid-run reset sequences. The ALU is modelled here combinationally.
module tb_alu_cmd_issue;
    import alu_pkg::*;

    localparam int W     = 8;
    localparam int DEPTH = 4;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic [7:0] exp;
    } vec_t;

    typedef struct {
        logic [7:0] res;
        logic [2:0] op;
    } exp_t;

    logic clock;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   n_rsp  = 0;
    exp_t exp_q[$];
    int   rsp_cyc_q[$];

    alu_cmd_issue_if #(.W(W), .DEPTH(DEPTH)) bus();

    alu_cmd_issue #(.W(W), .DEPTH(DEPTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [2:0] op);
        case (op)
            3'b100:  return a + b;
            3'b010:  return a - b;
            3'b001:  return a & b;
            3'b110:  return a | b;
            3'b011:  return a ^ b;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic tb_legal(input logic [2:0] op);
        return (op == 3'b100) || (op == 3'b010) || (op == 3'b001) ||
               (op == 3'b110) || (op == 3'b011);
    endfunction

    // Combinational ALU model fed by the DUT's drive outputs.
    always_comb bus.alu_result = alu_model(bus.alu_a, bus.alu_b, bus.alu_op);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every completed response transfer is checked against the queue.
    always @(negedge clock) begin
        if (!reset && bus.rsp_valid && bus.rsp_ready) begin
            n_rsp++;
            rsp_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 32'(bus.rsp_result), 32'hffff_ffff);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_result", 32'(bus.rsp_result), 32'(e.res));
                chk("rsp_op", 32'(bus.rsp_op), 32'(e.op));
            end
        end
    end

    // Present a command and hold it until accepted; returns just after the accepting edge.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input logic [7:0] exp, output int acc_edge);
        int   n;
        exp_t e;
        n = 0;
        acc_edge = -1;
        bus.cmd_valid = 1'b1;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_op    = op;
        @(negedge clock);
        while (!bus.cmd_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("cmd_accept", 32'(bus.cmd_ready), 32'h1);
        if (bus.cmd_ready) begin
            acc_edge = cyc + 1;
            if (tb_legal(op)) begin
                e.res = exp;
                e.op  = op;
                exp_q.push_back(e);
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.cmd_valid = 1'b0;
        bus.cmd_a     = 8'h00;
        bus.cmd_b     = 8'h00;
        bus.cmd_op    = 3'b100;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.rsp_valid || bus.count != 0) && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk(name, 32'(exp_q.size()), 32'h0);
    endtask

    // Watchdog: the run must never hang.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[8];
        int   e;
        int   first;
        int   base;
        logic [7:0] r1;
        logic [7:0] av;

        vecs[0] = '{8'h35, 8'h15, 3'b100, 8'h4a};
        vecs[1] = '{8'h35, 8'h15, 3'b010, 8'h20};
        vecs[2] = '{8'h35, 8'h15, 3'b001, 8'h15};
        vecs[3] = '{8'h35, 8'h15, 3'b110, 8'h35};
        vecs[4] = '{8'h35, 8'h15, 3'b011, 8'h20};
        vecs[5] = '{8'hff, 8'h01, 3'b100, 8'h00};
        vecs[6] = '{8'h00, 8'h01, 3'b010, 8'hff};
        vecs[7] = '{8'hff, 8'hff, 3'b011, 8'h00};

        reset = 1'b1;
        bus.rsp_ready = 1'b0;
        idle();

        // Reset state
        #12;
        chk("rst_count", 32'(bus.count), 32'h0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_rsp_result", 32'(bus.rsp_result), 32'h0);
        chk("rst_rsp_op", 32'(bus.rsp_op), 32'h4);
        chk("rst_err", 32'(bus.err_illegal), 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'h1);
        chk("idle_alu_op", 32'(bus.alu_op), 32'h4);

        // Streaming table, including the wrap cases
        bus.rsp_ready = 1'b1;
        rsp_cyc_q.delete();
        first = 0;
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp, e);
            if (i == 0) first = e;
        end
        idle();
        wait_drain("stream_drain");
        chk("stream_n", 32'(rsp_cyc_q.size()), 32'd8);
        for (int k = 0; k < 8; k++) begin
            if (k < rsp_cyc_q.size()) chk("stream_cyc", 32'(rsp_cyc_q[k]), 32'(first + 1 + k));
        end

        // Backpressure: 5 accepted, sixth refused, results held then drained in order
        bus.rsp_ready = 1'b0;
        base = n_rsp;
        r1 = alu_model(8'h11, 8'h01, 3'b100);
        for (int i = 0; i < 5; i++) begin
            av = 8'h11 * 8'(i + 1);
            send(av, 8'(i + 1), 3'b100, alu_model(av, 8'(i + 1), 3'b100), e);
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_a     = 8'h77;
        bus.cmd_b     = 8'h01;
        bus.cmd_op    = 3'b100;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("bp_cmd_ready", 32'(bus.cmd_ready), 32'h0);
            chk("bp_count", 32'(bus.count), 32'h4);
            chk("bp_hold_valid", 32'(bus.rsp_valid), 32'h1);
            chk("bp_hold_result", 32'(bus.rsp_result), 32'(r1));
            chk("bp_hold_op", 32'(bus.rsp_op), 32'h4);
        end
        @(posedge clock);
        #1;
        idle();
        bus.rsp_ready = 1'b1;
        wait_drain("bp_drain");
        chk("bp_nrsp", 32'(n_rsp - base), 32'd5);

        // Illegal op between two legal commands
        base = n_rsp;
        chk("ill_err_before", 32'(bus.err_illegal), 32'h0);
        send(8'h01, 8'h02, 3'b100, 8'h03, e);
        send(8'h55, 8'h66, 3'b111, 8'h00, e);
        chk("ill_err_set", 32'(bus.err_illegal), 32'h1);
        chk("ill_count", 32'(bus.count), 32'h0);
        send(8'h03, 8'h04, 3'b100, 8'h07, e);
        idle();
        wait_drain("ill_drain");
        chk("ill_nrsp", 32'(n_rsp - base), 32'd2);
        chk("ill_err_sticky", 32'(bus.err_illegal), 32'h1);

        // Full FIFO with a response leaving and a push offered in the same cycle
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(8'(i * 3), 8'h10, 3'b110, alu_model(8'(i * 3), 8'h10, 3'b110), e);
        end
        idle();
        bus.rsp_ready = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_a     = 8'h80;
        bus.cmd_b     = 8'h81;
        bus.cmd_op    = 3'b100;
        @(negedge clock);
        chk("full_cmd_ready", 32'(bus.cmd_ready), 32'h0);
        chk("full_count", 32'(bus.count), 32'h4);
        @(posedge clock);
        #1;
        chk("full_count_after_pop", 32'(bus.count), 32'h3);
        send(8'h80, 8'h81, 3'b100, 8'h01, e);
        chk("full_count_pushpop", 32'(bus.count), 32'h3);
        idle();
        wait_drain("full_drain");

        // Asynchronous reset in the middle of a stalled run
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(8'h20, 8'(i), 3'b010, alu_model(8'h20, 8'(i), 3'b010), e);
        end
        idle();
        chk("mid_count", 32'(bus.count), 32'h3);
        chk("mid_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_count", 32'(bus.count), 32'h0);
        chk("arst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("arst_rsp_result", 32'(bus.rsp_result), 32'h0);
        chk("arst_rsp_op", 32'(bus.rsp_op), 32'h4);
        chk("arst_err", 32'(bus.err_illegal), 32'h0);
        exp_q.delete();
        base = n_rsp;
        @(posedge clock);
        #1;
        reset = 1'b0;
        bus.rsp_ready = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        chk("arst_no_stale", 32'(n_rsp - base), 32'h0);
        chk("arst_cmd_ready", 32'(bus.cmd_ready), 32'h1);
        send(8'h0a, 8'h03, 3'b010, 8'h07, e);
        idle();
        wait_drain("arst_drain");
        chk("arst_nrsp", 32'(n_rsp - base), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
